regbus_sequencer: RTL and testbench

//  Sequences register-block transactions (load reg number, then write or read, then capture readback)
//  on behalf of two requesters: req0 = Master FPGA link command decoder, req1 = internal config/monitor engine.

---
 rtl/regbus_sequencer.sv | 134 +++++++++++++
 tb/tb_regbus_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_sequencer.sv
// Register-block transaction sequencer: arbitrates two requesters and runs one
// load-reg / write-or-read / capture sequence at a time against the register block.
module regbus_sequencer #(
    parameter int PRIO_MODE = 0,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wr,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] rb_rx_data,
    output logic        rb_reg_num_le,
    output logic        rb_wr_en,
    output logic        rb_rd_en,
    input  logic [31:0] rb_tx_data,
    input  logic        rb_illegal,
    output logic        busy,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {IDLE, SEL, CHK, ACC, CAP, RSP} state_t;

    state_t      state, state_nx;
    logic        gsel;
    logic        gnt, last_grant;
    logic        wr_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  cap_cnt;

    // Lone requester wins outright; on contention round-robin flips away from
    // the last winner, fixed priority always picks req0.
    always_comb begin
        gsel = ~req_valid[0];
        if (PRIO_MODE == 0 && req_valid == 2'b11)
            gsel = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        req_ready     = 2'b00;
        rsp_valid     = 2'b00;
        rb_rx_data    = 32'd0;
        rb_reg_num_le = 1'b0;
        rb_wr_en      = 1'b0;
        rb_rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid && !reset) begin
                    req_ready = gsel ? 2'b10 : 2'b01;
                    state_nx  = SEL;
                end
            end
            SEL: begin
                rb_rx_data    = addr_q;
                rb_reg_num_le = 1'b1;
                state_nx      = CHK;
            end
            CHK: state_nx = rb_illegal ? RSP : ACC;
            ACC: begin
                if (wr_q) begin
                    rb_rx_data = wdata_q;
                    rb_wr_en   = 1'b1;
                    state_nx   = RSP;
                end else begin
                    rb_rd_en = 1'b1;
                    state_nx = CAP;
                end
            end
            CAP: if (cap_cnt == 3'd0) state_nx = RSP;
            RSP: begin
                rsp_valid = gnt ? 2'b10 : 2'b01;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign rsp_rdata = (state == RSP) ? rdata_q : 32'd0;
    assign rsp_err   = (state == RSP) & err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            cap_cnt    <= 3'd0;
            err_count  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nx == SEL) begin
                        gnt     <= gsel;
                        wr_q    <= req_wr[gsel];
                        addr_q  <= gsel ? req_addr[63:32]  : req_addr[31:0];
                        wdata_q <= gsel ? req_wdata[63:32] : req_wdata[31:0];
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                    end
                end
                CHK: begin
                    if (rb_illegal) begin
                        err_q <= 1'b1;
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    end
                end
                ACC: cap_cnt <= 3'(RD_LAT - 1);
                // Readback is taken on the edge closing the last capture cycle.
                CAP: begin
                    if (cap_cnt == 3'd0) rdata_q <= rb_tx_data;
                    else                 cap_cnt <= cap_cnt - 3'd1;
                end
                RSP: last_grant <= gnt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_sequencer.sv
// Bench for regbus_sequencer: two instances (round-robin/RD_LAT=1, fixed-priority/RD_LAT=3)
// checked each cycle against a latency-schedule model, plus directed literal expectations.
module tb_regbus_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  req_valid [2];
    logic [1:0]  req_ready [2];
    logic [1:0]  req_wr    [2];
    logic [63:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [1:0]  rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic [31:0] rb_rx_data [2];
    logic        rb_reg_num_le [2];
    logic        rb_wr_en  [2];
    logic        rb_rd_en  [2];
    logic [31:0] rb_tx_data [2];
    logic        rb_illegal [2];
    logic        busy      [2];
    logic [15:0] err_count [2];

    regbus_sequencer #(.PRIO_MODE(0), .RD_LAT(1)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .rb_rx_data(rb_rx_data[0]), .rb_reg_num_le(rb_reg_num_le[0]),
        .rb_wr_en(rb_wr_en[0]), .rb_rd_en(rb_rd_en[0]),
        .rb_tx_data(rb_tx_data[0]), .rb_illegal(rb_illegal[0]),
        .busy(busy[0]), .err_count(err_count[0]));

    regbus_sequencer #(.PRIO_MODE(1), .RD_LAT(3)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .rb_rx_data(rb_rx_data[1]), .rb_reg_num_le(rb_reg_num_le[1]),
        .rb_wr_en(rb_wr_en[1]), .rb_rd_en(rb_rd_en[1]),
        .rb_tx_data(rb_tx_data[1]), .rb_illegal(rb_illegal[1]),
        .busy(busy[1]), .err_count(err_count[1]));

    // Register block stand-in: remembers the loaded register number and flags it illegal.
    logic [31:0] regnum [2];
    always @(posedge clk) begin
        if (rb_reg_num_le[0]) regnum[0] <= rb_rx_data[0];
        if (rb_reg_num_le[1]) regnum[1] <= rb_rx_data[1];
    end
    assign rb_illegal[0] = |regnum[0][31:5];
    assign rb_illegal[1] = |regnum[1][31:5];

    function automatic int rdl(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    int checks = 0;
    int errors = 0;
    int tmo = 0;
    int tmo_ack = 0;

    bit          pin_on    [2] = '{1'b0, 1'b0};
    logic [31:0] pin_rdata [2];
    bit          pin_err   [2];
    logic [15:0] pin_cnt   [2];
    bit          pin_g     [2];
    int          pin_lat   [2];

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %h required %h", nm, d, cyc, got, exp);
        end
    endtask

    // Model: once a request is accepted at cycle t0, every output is a fixed function
    // of (cycle - t0), the request and the readback history.
    bit          act   [2] = '{1'b0, 1'b0};
    bit          last  [2] = '{1'b1, 1'b1};
    int          t0    [2];
    bit          m_wr  [2], m_err [2], m_g [2];
    logic [31:0] m_addr [2], m_wdata [2];
    logic [15:0] mcnt  [2] = '{16'd0, 16'd0};
    logic [31:0] tx_hist [2][64];

    initial forever begin
        logic [1:0]  e_ready, e_rv;
        logic        e_busy, e_le, e_wen, e_ren, e_err;
        logic [31:0] e_rx, e_rdata;
        int          k, lat;
        bit          g;
        @(negedge clk);
        chk("wait_bound", -1, 32'(tmo), 32'(tmo_ack));
        tmo_ack = tmo;
        for (int d = 0; d < 2; d++) begin
            tx_hist[d][cyc % 64] = rb_tx_data[d];
            e_ready = 2'b00; e_rv = 2'b00; e_busy = 0; e_le = 0; e_wen = 0; e_ren = 0;
            e_err = 0; e_rx = 0; e_rdata = 0; k = 0; lat = 0; g = 0;
            if (act[d]) begin
                k   = cyc - t0[d];
                lat = m_err[d] ? 4 : (m_wr[d] ? 5 : 5 + rdl(d));
                e_busy = 1;
                if (k == 1) begin e_le = 1; e_rx = m_addr[d]; end
                if (k == 3 && !m_err[d]) begin
                    if (m_wr[d]) begin e_wen = 1; e_rx = m_wdata[d]; end
                    else e_ren = 1;
                end
                if (k == lat - 1) begin
                    e_rv  = m_g[d] ? 2'b10 : 2'b01;
                    e_err = m_err[d];
                    if (!m_wr[d] && !m_err[d]) e_rdata = tx_hist[d][(t0[d] + 3 + rdl(d)) % 64];
                    if (m_err[d] && mcnt[d] != 16'hFFFF) mcnt[d]++;
                end
            end else if (!reset && req_valid[d] != 2'b00) begin
                if (req_valid[d] == 2'b11) g = (d == 1) ? 1'b0 : !last[d];
                else                       g = req_valid[d][1];
                e_ready = g ? 2'b10 : 2'b01;
            end
            chk("req_ready", d, 32'(req_ready[d]), 32'(e_ready));
            chk("busy", d, 32'(busy[d]), 32'(e_busy));
            chk("reg_num_le", d, 32'(rb_reg_num_le[d]), 32'(e_le));
            chk("wr_en", d, 32'(rb_wr_en[d]), 32'(e_wen));
            chk("rd_en", d, 32'(rb_rd_en[d]), 32'(e_ren));
            chk("rx_data", d, rb_rx_data[d], e_rx);
            chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(e_rv));
            chk("rsp_rdata", d, rsp_rdata[d], e_rdata);
            chk("rsp_err", d, 32'(rsp_err[d]), 32'(e_err));
            chk("err_count", d, 32'(err_count[d]), 32'(mcnt[d]));
            if (e_rv != 2'b00 && pin_on[d]) begin
                chk("pin_rdata", d, rsp_rdata[d], pin_rdata[d]);
                chk("pin_err", d, 32'(rsp_err[d]), 32'(pin_err[d]));
                chk("pin_err_count", d, 32'(err_count[d]), 32'(pin_cnt[d]));
                chk("pin_grant", d, 32'(rsp_valid[d]), pin_g[d] ? 32'd2 : 32'd1);
                chk("pin_latency", d, 32'(k + 1), 32'(pin_lat[d]));
            end
            if (reset) begin
                act[d] = 0; last[d] = 1; mcnt[d] = 16'd0;
            end else if (act[d]) begin
                if (k == lat - 1) begin act[d] = 0; last[d] = m_g[d]; end
            end else if (e_ready != 2'b00) begin
                act[d]     = 1;
                t0[d]      = cyc;
                m_g[d]     = g;
                m_wr[d]    = req_wr[d][g];
                m_addr[d]  = g ? req_addr[d][63:32]  : req_addr[d][31:0];
                m_wdata[d] = g ? req_wdata[d][63:32] : req_wdata[d][31:0];
                m_err[d]   = |m_addr[d][31:5];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input int n, input bit wr, input logic [31:0] a, input logic [31:0] w);
        req_valid[d][n] = 1'b1;
        req_wr[d][n]    = wr;
        if (n == 0) begin req_addr[d][31:0]  = a; req_wdata[d][31:0]  = w; end
        else        begin req_addr[d][63:32] = a; req_wdata[d][63:32] = w; end
    endtask

    task automatic pin(input int d, input logic [31:0] rdata, input bit err, input logic [15:0] cnt,
                       input bit g, input int lat);
        pin_on[d] = 1; pin_rdata[d] = rdata; pin_err[d] = err; pin_cnt[d] = cnt;
        pin_g[d] = g; pin_lat[d] = lat;
    endtask

    task automatic wait_acc(input int d, input int n);
        bit got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_valid[d][n] && req_ready[d][n];
        end
        if (!got) tmo++;
        step();
        req_valid[d][n] = 1'b0;
    endtask

    task automatic wait_rsp(input int d);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (rsp_valid[d] != 2'b00);
        end
        if (!got) tmo++;
        step();
        pin_on[d] = 0;
    endtask

    initial begin
        logic [1:0] acc [2];
        logic [3:0] gs;
        int nacc, nrsp;
        bit got;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 2'b00; req_wr[d] = 2'b00; req_addr[d] = 64'd0;
            req_wdata[d] = 64'd0; rb_tx_data[d] = 32'd0;
        end
        repeat (3) step();
        reset = 1'b0;
        step();

        // req0 write reg 2
        pin(0, 32'd0, 0, 16'd0, 0, 5);
        issue(0, 0, 1, 32'h2, 32'd70000);
        wait_acc(0, 0);
        wait_rsp(0);

        // req1 read reg 0x1F
        rb_tx_data[0] = 32'h00010203;
        pin(0, 32'h00010203, 0, 16'd0, 1, 6);
        issue(0, 1, 0, 32'h1F, 32'd0);
        wait_acc(0, 1);
        wait_rsp(0);

        // illegal register number
        pin(0, 32'd0, 1, 16'd1, 0, 4);
        issue(0, 0, 1, 32'h20, 32'h1234);
        wait_acc(0, 0);
        wait_rsp(0);

        // contention: both requesters held for four transactions
        reset = 1'b1; step(); step(); reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            gs = (d == 0) ? 4'b1010 : 4'b0000;
            nacc = 0; nrsp = 0;
            pin(d, 32'd0, 0, 16'd0, gs[0], 5);
            issue(d, 0, 1, 32'h3, 32'hB0);
            issue(d, 1, 1, 32'h4, 32'hB1);
            for (int c = 0; c < 200 && nrsp < 4; c++) begin
                @(negedge clk);
                if ((req_valid[d] & req_ready[d]) != 2'b00) nacc++;
                if (rsp_valid[d] != 2'b00) nrsp++;
                step();
                if (nacc >= 4) req_valid[d] = 2'b00;
                if (nrsp < 4) pin_g[d] = gs[nrsp];
            end
            if (nrsp < 4) tmo++;
            req_valid[d] = 2'b00;
            pin_on[d] = 0;
            step();
        end

        // reset while the read strobe is on the bus, then a clean read
        rb_tx_data[0] = 32'h5555AAAA;
        issue(0, 0, 0, 32'h5, 32'd0);
        wait_acc(0, 0);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        rb_tx_data[0] = 32'hCAFE0005;
        pin(0, 32'hCAFE0005, 0, 16'd0, 1, 6);
        issue(0, 1, 0, 32'h5, 32'd0);
        wait_acc(0, 1);
        wait_rsp(0);

        // RD_LAT=3 capture with readback changing every cycle
        pin(1, 32'hA0000006, 0, 16'd0, 0, 8);
        issue(1, 0, 0, 32'h7, 32'd0);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_valid[1][0] && req_ready[1][0];
        end
        if (!got) tmo++;
        got = 0;
        for (int j = 1; j <= 20 && !got; j++) begin
            step();
            if (j == 1) req_valid[1][0] = 1'b0;
            rb_tx_data[1] = 32'hA0000000 + 32'(j);
            @(negedge clk);
            got = (rsp_valid[1] != 2'b00);
        end
        if (!got) tmo++;
        step();
        pin_on[1] = 0;

        // randomized traffic with withdrawals and illegal numbers
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) acc[d] = req_valid[d] & req_ready[d];
            step();
            for (int d = 0; d < 2; d++) begin
                rb_tx_data[d] = $urandom;
                for (int n = 0; n < 2; n++) begin
                    if (req_valid[d][n]) begin
                        if (acc[d][n] || $urandom_range(0, 15) == 0) req_valid[d][n] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        issue(d, n, 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 31),
                              $urandom);
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) req_valid[d] = 2'b00;
        repeat (20) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
